// File: rtl/fp_lane_unpacker.sv
// fp_lane_unpacker: takes one packed FP result word plus its format tag,
// widens every lane to IEEE FP32 and streams the lanes out one per beat.

`ifndef CONFIG_WIDTH
`define CONFIG_WIDTH 3
`endif
`ifndef CONFIG_FP32
`define CONFIG_FP32     3'd0
`endif
`ifndef CONFIG_TF32
`define CONFIG_TF32     3'd1
`endif
`ifndef CONFIG_FP16
`define CONFIG_FP16     3'd2
`endif
`ifndef CONFIG_BF16
`define CONFIG_BF16     3'd3
`endif
`ifndef CONFIG_FP8_E4M3
`define CONFIG_FP8_E4M3 3'd4
`endif
`ifndef CONFIG_FP8_E5M2
`define CONFIG_FP8_E5M2 3'd5
`endif

module fp_lane_unpacker #(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [31:0]              IN_DATA,
  input  logic [`CONFIG_WIDTH-1:0] IN_CONFIG,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [31:0]              OUT_DATA,
  output logic [1:0]               OUT_LANE,
  output logic                     OUT_LAST,
  output logic                     CFG_ERR,
  output logic [DROP_CNT_W-1:0]    DROP_CNT
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                   state, state_nxt;
  logic [31:0]              data_q;
  logic [`CONFIG_WIDTH-1:0] fmt_q;
  logic [1:0]               beat_q;
  logic                     cfg_err_q;
  logic [DROP_CNT_W-1:0]    drop_q;

  logic       accept, cfg_ok, load, advance, err_set;
  logic [1:0] last_idx, lane_phys;
  logic [15:0] lane16;
  logic [7:0]  lane8;
  logic [31:0] conv;

  // classify the incoming format tag
  always_comb begin
    cfg_ok = 1'b0;
    unique case (IN_CONFIG)
      `CONFIG_FP32, `CONFIG_TF32, `CONFIG_FP16,
      `CONFIG_BF16, `CONFIG_FP8_E4M3, `CONFIG_FP8_E5M2: cfg_ok = 1'b1;
      default: cfg_ok = 1'b0;
    endcase
  end

  // index of the final beat for the held word, and the physical lane of this beat
  always_comb begin
    last_idx = 2'd0;
    unique case (fmt_q)
      `CONFIG_FP16, `CONFIG_BF16:         last_idx = 2'd1;
      `CONFIG_FP8_E4M3, `CONFIG_FP8_E5M2: last_idx = 2'd3;
      default:                            last_idx = 2'd0;
    endcase
    lane_phys = MSB_FIRST ? (last_idx - beat_q) : beat_q;
  end

  assign OUT_VALID = (state == EMIT);
  assign OUT_LAST  = OUT_VALID & (beat_q == last_idx);
  // a word may be taken while the previous word's final lane is leaving
  assign IN_READY  = (state == IDLE) | (OUT_VALID & OUT_READY & OUT_LAST);
  assign accept    = IN_VALID & IN_READY;

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    err_set   = 1'b0;
    if (accept) begin
      if (cfg_ok) begin
        state_nxt = EMIT;
        load      = 1'b1;
      end else begin
        state_nxt = IDLE;
        err_set   = 1'b1;
      end
    end else if (state == EMIT && OUT_READY) begin
      if (OUT_LAST) state_nxt = IDLE;
      else          advance   = 1'b1;
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // held word, beat counter and drop accounting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q    <= '0;
      fmt_q     <= `CONFIG_FP32;
      beat_q    <= '0;
      cfg_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (load) begin
        data_q <= IN_DATA;
        fmt_q  <= IN_CONFIG;
        beat_q <= '0;
      end else if (advance) begin
        beat_q <= beat_q + 2'd1;
      end
      cfg_err_q <= err_set;
      if (err_set && drop_q != '1) drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  // pick the raw lane bits out of the held word
  always_comb begin
    lane16 = lane_phys[0] ? data_q[31:16] : data_q[15:0];
    unique case (lane_phys)
      2'd0:    lane8 = data_q[7:0];
      2'd1:    lane8 = data_q[15:8];
      2'd2:    lane8 = data_q[23:16];
      default: lane8 = data_q[31:24];
    endcase
  end

  // widen the selected lane to FP32; zero exponents flush to signed zero
  always_comb begin
    conv = '0;
    unique case (fmt_q)
      `CONFIG_FP32: conv = data_q;
      `CONFIG_TF32: conv = {data_q[31:13], 13'b0};
      `CONFIG_FP16: begin
        if (lane16[14:10] == 5'd0)       conv = {lane16[15], 31'b0};
        else if (lane16[14:10] == 5'h1F) conv = {lane16[15], 8'hFF, lane16[9:0], 13'b0};
        else conv = {lane16[15], {3'b0, lane16[14:10]} + 8'd112, lane16[9:0], 13'b0};
      end
      `CONFIG_BF16: begin
        if (lane16[14:7] == 8'd0) conv = {lane16[15], 31'b0};
        else                      conv = {lane16[15], lane16[14:7], lane16[6:0], 16'b0};
      end
      `CONFIG_FP8_E5M2: begin
        if (lane8[6:2] == 5'd0)       conv = {lane8[7], 31'b0};
        else if (lane8[6:2] == 5'h1F) conv = {lane8[7], 8'hFF, lane8[1:0], 21'b0};
        else conv = {lane8[7], {3'b0, lane8[6:2]} + 8'd112, lane8[1:0], 21'b0};
      end
      `CONFIG_FP8_E4M3: begin
        if (lane8[6:3] == 4'd0)       conv = {lane8[7], 31'b0};
        else if (lane8[6:0] == 7'h7F) conv = {lane8[7], 8'hFF, 23'h400000};
        else conv = {lane8[7], {4'b0, lane8[6:3]} + 8'd120, lane8[2:0], 20'b0};
      end
      default: conv = '0;
    endcase
  end

  assign OUT_DATA = OUT_VALID ? conv : '0;
  assign OUT_LANE = OUT_VALID ? lane_phys : 2'd0;
  assign CFG_ERR  = cfg_err_q;
  assign DROP_CNT = drop_q;

endmodule
